enemy_pool_ctrl: RTL and testbench



---
 rtl/enemy_pool_ctrl.sv | 147 ++++++++++++++
 tb/tb_enemy_pool_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_pool_ctrl.sv
// Pool of N enemy slots: handshake spawns into the lowest free slot, per-frame
// movement with edge bounce / vertical exit, and per-slot kill strobes.
module enemy_pool_ctrl #(
    parameter int N         = 4,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPRITE    = 32,
    parameter int WRAP_MODE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   spawn_valid,
    output logic                   spawn_ready,
    input  logic [XW-1:0]          spawn_x,
    input  logic [YW-1:0]          spawn_y,
    input  logic [3:0]             spawn_dx,
    input  logic [3:0]             spawn_dy,
    input  logic [N-1:0]           hit_flat,
    output logic [XW*N-1:0]        enemy_x_flat,
    output logic [YW*N-1:0]        enemy_y_flat,
    output logic [N-1:0]           enemy_alive_flat,
    output logic [N-1:0]           despawn_flat,
    output logic [$clog2(N+1)-1:0] alive_count
);
    localparam int CW = $clog2(N + 1);
    localparam int SW = ((XW > YW) ? XW : YW) + 2;

    localparam logic [XW-1:0]        X_MAX_V = XW'(SCREEN_W - SPRITE);
    localparam logic [YW-1:0]        Y_MAX_V = YW'(SCREEN_H - SPRITE);
    localparam logic signed [SW-1:0] X_MAX_S = SW'(SCREEN_W - SPRITE);
    localparam logic signed [SW-1:0] H_S     = SW'(SCREEN_H);

    logic [N-1:0] alive_vec;
    logic [N-1:0] spawn_sel;
    logic         spawn_fire;
    logic [XW-1:0] spawn_x_clamped;
    logic [YW-1:0] spawn_y_clamped;

    // Reversing a -8 velocity cannot be represented, so it saturates to +7.
    function automatic logic signed [3:0] neg_sat(input logic signed [3:0] v);
        return (v == 4'sb1000) ? 4'sb0111 : -v;
    endfunction

    assign spawn_ready     = ~(&alive_vec) & ~reset;
    assign spawn_fire      = spawn_valid & spawn_ready;
    assign spawn_x_clamped = (spawn_x > X_MAX_V) ? X_MAX_V : spawn_x;
    assign spawn_y_clamped = (spawn_y > Y_MAX_V) ? Y_MAX_V : spawn_y;

    always_comb begin
        logic found;
        spawn_sel = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!alive_vec[i] && !found) begin
                spawn_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        alive_count = '0;
        for (int i = 0; i < N; i++) begin
            alive_count = alive_count + CW'(alive_vec[i]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            logic [XW-1:0]        x_q, x_d;
            logic [YW-1:0]        y_q, y_d;
            logic signed [3:0]    dx_q, dx_d;
            logic signed [3:0]    dy_q, dy_d;
            logic                 alive_q, alive_d;
            logic                 despawn_q, despawn_d;
            logic signed [SW-1:0] nx, ny;

            always_comb begin
                nx        = $signed({{(SW-XW){1'b0}}, x_q}) + $signed({{(SW-4){dx_q[3]}}, dx_q});
                ny        = $signed({{(SW-YW){1'b0}}, y_q}) + $signed({{(SW-4){dy_q[3]}}, dy_q});
                x_d       = x_q;
                y_d       = y_q;
                dx_d      = dx_q;
                dy_d      = dy_q;
                alive_d   = alive_q;
                despawn_d = 1'b0;
                if (spawn_fire && spawn_sel[gi]) begin
                    x_d     = spawn_x_clamped;
                    y_d     = spawn_y_clamped;
                    dx_d    = $signed(spawn_dx);
                    dy_d    = $signed(spawn_dy);
                    alive_d = 1'b1;
                end else if (alive_q && hit_flat[gi]) begin
                    alive_d = 1'b0;
                end else if (alive_q && frame_tick) begin
                    if (nx < 0) begin
                        x_d  = '0;
                        dx_d = neg_sat(dx_q);
                    end else if (nx > X_MAX_S) begin
                        x_d  = X_MAX_V;
                        dx_d = neg_sat(dx_q);
                    end else begin
                        x_d = nx[XW-1:0];
                    end
                    if (ny >= H_S || ny < 0) begin
                        if (WRAP_MODE != 0) begin
                            y_d = (ny < 0) ? Y_MAX_V : '0;
                        end else begin
                            alive_d   = 1'b0;
                            despawn_d = 1'b1;
                        end
                    end else begin
                        y_d = ny[YW-1:0];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    x_q       <= '0;
                    y_q       <= '0;
                    dx_q      <= '0;
                    dy_q      <= '0;
                    alive_q   <= 1'b0;
                    despawn_q <= 1'b0;
                end else begin
                    x_q       <= x_d;
                    y_q       <= y_d;
                    dx_q      <= dx_d;
                    dy_q      <= dy_d;
                    alive_q   <= alive_d;
                    despawn_q <= despawn_d;
                end
            end

            assign alive_vec[gi]                 = alive_q;
            assign enemy_alive_flat[gi]          = alive_q;
            assign despawn_flat[gi]              = despawn_q;
            assign enemy_x_flat[gi*XW +: XW]     = x_q;
            assign enemy_y_flat[gi*YW +: YW]     = y_q;
        end
    endgenerate
endmodule

// File: tb/tb_enemy_pool_ctrl.sv
// Bench for enemy_pool_ctrl: despawn and wrap variants driven in lockstep and
// checked against a slot-level behavioural model.
module tb_enemy_pool_ctrl;
    localparam int N  = 4;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int XMAX = 640 - 32;
    localparam int YMAX = 480 - 32;

    logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, spawn_valid = 1'b0;
    logic [XW-1:0] spawn_x = '0;
    logic [YW-1:0] spawn_y = '0;
    logic [3:0] spawn_dx = '0, spawn_dy = '0;
    logic [N-1:0] hit_flat = '0;

    logic           rdy [2];
    logic [XW*N-1:0] xf [2];
    logic [YW*N-1:0] yf [2];
    logic [N-1:0]   af [2];
    logic [N-1:0]   df [2];
    logic [2:0]     cnt [2];

    int n_cmp = 0, n_fail = 0;

    // Model state, index 0 = despawn variant, 1 = wrap variant
    int mx [2][N], my [2][N], mdx [2][N], mdy [2][N];
    bit ma [2][N], md [2][N];

    always #5 clk = ~clk;

    enemy_pool_ctrl #(.N(N), .XW(XW), .YW(YW), .WRAP_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .spawn_valid(spawn_valid),
        .spawn_ready(rdy[0]), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dx(spawn_dx),
        .spawn_dy(spawn_dy), .hit_flat(hit_flat), .enemy_x_flat(xf[0]), .enemy_y_flat(yf[0]),
        .enemy_alive_flat(af[0]), .despawn_flat(df[0]), .alive_count(cnt[0]));

    enemy_pool_ctrl #(.N(N), .XW(XW), .YW(YW), .WRAP_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .spawn_valid(spawn_valid),
        .spawn_ready(rdy[1]), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dx(spawn_dx),
        .spawn_dy(spawn_dy), .hit_flat(hit_flat), .enemy_x_flat(xf[1]), .enemy_y_flat(yf[1]),
        .enemy_alive_flat(af[1]), .despawn_flat(df[1]), .alive_count(cnt[1]));

    function automatic int turn(input int v);
        return (v == -8) ? 7 : -v;
    endfunction

    // Applies the pool rules to the model using the inputs present before the edge.
    task automatic model_edge();
        int nx, ny, tgt;
        for (int w = 0; w < 2; w++) begin
            tgt = -1;
            if (!reset && spawn_valid)
                for (int i = 0; i < N; i++)
                    if (!ma[w][i] && tgt < 0) tgt = i;
            if (w == 0 && tgt >= 0)
                $display("[%0t] spawn -> slot %0d x=%0d y=%0d dx=%0d dy=%0d", $time, tgt,
                         spawn_x, spawn_y, $signed(spawn_dx), $signed(spawn_dy));
            for (int i = 0; i < N; i++) begin
                md[w][i] = 0;
                if (reset) begin
                    mx[w][i] = 0; my[w][i] = 0; mdx[w][i] = 0; mdy[w][i] = 0; ma[w][i] = 0;
                end else if (i == tgt) begin
                    mx[w][i]  = (int'(spawn_x) > XMAX) ? XMAX : int'(spawn_x);
                    my[w][i]  = (int'(spawn_y) > YMAX) ? YMAX : int'(spawn_y);
                    mdx[w][i] = int'($signed(spawn_dx));
                    mdy[w][i] = int'($signed(spawn_dy));
                    ma[w][i]  = 1;
                end else if (ma[w][i] && hit_flat[i]) begin
                    ma[w][i] = 0;
                end else if (ma[w][i] && frame_tick) begin
                    nx = mx[w][i] + mdx[w][i];
                    ny = my[w][i] + mdy[w][i];
                    if (nx < 0) begin
                        mx[w][i] = 0; mdx[w][i] = turn(mdx[w][i]);
                    end else if (nx > XMAX) begin
                        mx[w][i] = XMAX; mdx[w][i] = turn(mdx[w][i]);
                    end else mx[w][i] = nx;
                    if (ny >= 480 || ny < 0) begin
                        if (w == 1) my[w][i] = (ny < 0) ? YMAX : 0;
                        else begin ma[w][i] = 0; md[w][i] = 1; end
                    end else my[w][i] = ny;
                end
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; spawn_valid = 1'b0; frame_tick = 1'b0; hit_flat = '0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic spawn(input int x, input int y, input int dx, input int dy);
        spawn_x = XW'(x); spawn_y = YW'(y); spawn_dx = 4'(dx); spawn_dy = 4'(dy);
        spawn_valid = 1'b1;
        cycle();
        spawn_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (rdy[w] !== 1'b0 || af[w] !== '0 || df[w] !== '0 || cnt[w] !== '0 ||
                xf[w] !== '0 || yf[w] !== '0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: rdy=%b alive=%b desp=%b cnt=%0d x=%h y=%h required all 0",
                         w, rdy[w], af[w], df[w], cnt[w], xf[w], yf[w]);
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b required 1", rdy[0]);
        end
    endtask

    task automatic test_spawn_move();
        do_reset();
        spawn(100, 50, 2, 3);
        n_cmp++;
        if (af[0] !== 4'b0001 || xf[0][0 +: XW] !== 10'd100 || yf[0][0 +: YW] !== 10'd50 || cnt[0] !== 3'd1) begin
            n_fail++;
            $display("FAIL spawn_load: alive=%b x=%0d y=%0d cnt=%0d required 0001/100/50/1",
                     af[0], xf[0][0 +: XW], yf[0][0 +: YW], cnt[0]);
        end
        tick();
        tick();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (xf[w][0 +: XW] !== 10'd104 || yf[w][0 +: YW] !== 10'd56) begin
                n_fail++;
                $display("FAIL move_two_ticks dut%0d: x=%0d y=%0d required 104/56", w,
                         xf[w][0 +: XW], yf[w][0 +: YW]);
            end
        end
    endtask

    task automatic test_fill_hold();
        do_reset();
        spawn(10, 10, 1, 1);
        spawn(20, 20, 1, 1);
        spawn(30, 30, 1, 1);
        spawn(700, 470, -1, -1);
        n_cmp++;
        if (rdy[0] !== 1'b0 || cnt[0] !== 3'd4 || xf[0][3*XW +: XW] !== 10'd608 || yf[0][3*YW +: YW] !== 10'd448) begin
            n_fail++;
            $display("FAIL fill_clamp: rdy=%b cnt=%0d x3=%0d y3=%0d required 0/4/608/448",
                     rdy[0], cnt[0], xf[0][3*XW +: XW], yf[0][3*YW +: YW]);
        end
        spawn_x = 10'd300; spawn_y = 10'd200; spawn_dx = 4'd0; spawn_dy = 4'd0;
        spawn_valid = 1'b1;
        cycle();
        n_cmp++;
        if (xf[0][2*XW +: XW] !== 10'd30 || cnt[0] !== 3'd4) begin
            n_fail++;
            $display("FAIL held_not_taken: x2=%0d cnt=%0d required 30/4", xf[0][2*XW +: XW], cnt[0]);
        end
        hit_flat = 4'b0100;
        cycle();
        hit_flat = '0;
        n_cmp++;
        if (af[0] !== 4'b1011 || df[0] !== 4'b0000 || xf[0][2*XW +: XW] !== 10'd30) begin
            n_fail++;
            $display("FAIL hit_frees_slot: alive=%b desp=%b x2=%0d required 1011/0000/30",
                     af[0], df[0], xf[0][2*XW +: XW]);
        end
        cycle();
        spawn_valid = 1'b0;
        n_cmp++;
        if (af[0] !== 4'b1111 || xf[0][2*XW +: XW] !== 10'd300 || yf[0][2*YW +: YW] !== 10'd200) begin
            n_fail++;
            $display("FAIL held_lands_slot2: alive=%b x2=%0d y2=%0d required 1111/300/200",
                     af[0], xf[0][2*XW +: XW], yf[0][2*YW +: YW]);
        end
    endtask

    task automatic test_x_bounce();
        int exp_x [5] = '{598, 602, 606, 608, 604};
        do_reset();
        spawn(594, 100, 4, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (int'(xf[0][0 +: XW]) !== exp_x[k]) begin
                n_fail++;
                $display("FAIL x_bounce tick%0d: x=%0d required %0d", k, xf[0][0 +: XW], exp_x[k]);
            end
        end
    endtask

    task automatic test_vertical_exit();
        do_reset();
        spawn(200, 448, 0, 3);
        for (int k = 0; k < 10; k++) tick();
        n_cmp++;
        if (yf[0][0 +: YW] !== 10'd478 || yf[1][0 +: YW] !== 10'd478) begin
            n_fail++;
            $display("FAIL y_approach: y0=%0d y1=%0d required 478", yf[0][0 +: YW], yf[1][0 +: YW]);
        end
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        n_cmp++;
        if (af[0][0] !== 1'b0 || df[0] !== 4'b0001 || yf[0][0 +: YW] !== 10'd478) begin
            n_fail++;
            $display("FAIL despawn_exit: alive=%b desp=%b y=%0d required 0/0001/478", af[0][0], df[0], yf[0][0 +: YW]);
        end
        n_cmp++;
        if (af[1][0] !== 1'b1 || df[1] !== 4'b0000 || yf[1][0 +: YW] !== 10'd0) begin
            n_fail++;
            $display("FAIL wrap_exit: alive=%b desp=%b y=%0d required 1/0000/0", af[1][0], df[1], yf[1][0 +: YW]);
        end
        cycle();
        n_cmp++;
        if (df[0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL despawn_one_cycle: desp=%b required 0000", df[0]);
        end
    endtask

    task automatic test_hit_vs_tick();
        do_reset();
        spawn(100, 100, 1, 1);
        spawn(200, 200, 1, 1);
        hit_flat = 4'b0010;
        frame_tick = 1'b1;
        cycle();
        hit_flat = '0;
        frame_tick = 1'b0;
        n_cmp++;
        if (af[0] !== 4'b0001 || df[0] !== 4'b0000 || xf[0][XW +: XW] !== 10'd200 || xf[0][0 +: XW] !== 10'd101) begin
            n_fail++;
            $display("FAIL hit_wins: alive=%b desp=%b x1=%0d x0=%0d required 0001/0000/200/101",
                     af[0], df[0], xf[0][XW +: XW], xf[0][0 +: XW]);
        end
        spawn_x = 10'd50; spawn_y = 10'd60; spawn_dx = 4'd5; spawn_dy = 4'd5;
        spawn_valid = 1'b1;
        frame_tick = 1'b1;
        cycle();
        spawn_valid = 1'b0;
        frame_tick = 1'b0;
        n_cmp++;
        if (af[0] !== 4'b0011 || xf[0][XW +: XW] !== 10'd50 || yf[0][YW +: YW] !== 10'd60 || xf[0][0 +: XW] !== 10'd102) begin
            n_fail++;
            $display("FAIL spawn_with_tick: alive=%b x1=%0d y1=%0d x0=%0d required 0011/50/60/102",
                     af[0], xf[0][XW +: XW], yf[0][YW +: YW], xf[0][0 +: XW]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        spawn(1, 2, 1, 1);
        spawn(3, 4, 1, 1);
        spawn(5, 6, 1, 1);
        reset = 1'b1;
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        n_cmp++;
        if (rdy[0] !== 1'b0 || af[0] !== '0 || cnt[0] !== '0 || xf[0] !== '0 || yf[0] !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%b alive=%b cnt=%0d x=%h y=%h required all 0",
                     rdy[0], af[0], cnt[0], xf[0], yf[0]);
        end
        reset = 1'b0;
        cycle();
        n_cmp++;
        if (rdy[0] !== 1'b1 || af[0] !== '0) begin
            n_fail++;
            $display("FAIL after_mid_reset: rdy=%b alive=%b required 1/0000", rdy[0], af[0]);
        end
    endtask

    task automatic test_random();
        bit bad;
        int live;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            spawn_valid = ($urandom_range(0, 2) == 0);
            spawn_x     = XW'($urandom_range(0, 1023));
            spawn_y     = YW'($urandom_range(0, 1023));
            spawn_dx    = 4'($urandom);
            spawn_dy    = 4'($urandom);
            frame_tick  = ($urandom_range(0, 1) == 0);
            hit_flat    = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            cycle();
            for (int w = 0; w < 2; w++) begin
                bad  = 0;
                live = 0;
                for (int i = 0; i < N; i++) begin
                    live += int'(ma[w][i]);
                    if (af[w][i] !== ma[w][i] || df[w][i] !== md[w][i] ||
                        int'(xf[w][i*XW +: XW]) !== mx[w][i] || int'(yf[w][i*YW +: YW]) !== my[w][i]) bad = 1;
                end
                if (int'(cnt[w]) !== live || rdy[w] !== (live < N)) bad = 1;
                n_cmp++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL random c%0d dut%0d: alive=%b desp=%b cnt=%0d rdy=%b x=%h y=%h required live=%0d x0=%0d y0=%0d",
                             c, w, af[w], df[w], cnt[w], rdy[w], xf[w], yf[w], live, mx[w][0], my[w][0]);
                end
            end
        end
        spawn_valid = 1'b0;
        frame_tick  = 1'b0;
        hit_flat    = '0;
    endtask

    initial begin
        test_reset();
        test_spawn_move();
        test_fill_hold();
        test_x_bounce();
        test_vertical_exit();
        test_hit_vs_tick();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
